// File: rtl/mm_bus_stage.sv
// Memory-access stage acting as a handshaked bus master for loads and stores.
// Optional bus-timeout abort is enabled by defining MM_BUS_TIMEOUT_EN.
module mm_bus_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mem_access_type,
  input  logic [2:0]            mem_access_size,
  input  logic                  mem_access_signed,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           data_i,
  input  logic [4:0]            reg_addr_i,
  output logic [31:0]           data_o,
  output logic [4:0]            reg_addr_o,
  output logic                  done_o,
  output logic                  stall_o,
  output logic                  alignment_err,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_be,
  output logic                  bus_read,
  output logic                  bus_write,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata
);

  localparam logic [1:0] T_LOAD   = 2'd1;
  localparam logic [1:0] T_STORE  = 2'd2;
  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_LEFT  = 3'd3;
  localparam logic [2:0] SZ_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] a,
                                         input logic is_load);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE:  be = 4'b0001 << a;
      SZ_HALF:  be = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD:  be = 4'b1111;
      SZ_LEFT:  be = is_load ? 4'b1111 : (4'b1111 >> (~a));
      SZ_RIGHT: be = is_load ? 4'b1111 : (4'b1111 << a);
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] size, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] w;
    w = 32'h0000_0000;
    case (size)
      SZ_BYTE:  w = {4{d[7:0]}};
      SZ_HALF:  w = {2{d[15:0]}};
      SZ_WORD:  w = d;
      SZ_LEFT:  w = d >> {~a, 3'b000};
      SZ_RIGHT: w = d << {a, 3'b000};
      default:  w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // LWL/LWR keep the bytes of the old rt value that the memory word does not cover
  function automatic logic [31:0] load_fmt(input logic [2:0] size, input logic sgn,
                                           input logic [1:0] a, input logic [31:0] d,
                                           input logic [31:0] rd);
    logic [31:0] lane;
    logic [15:0] half;
    logic [31:0] r;
    lane = rd >> {a, 3'b000};
    half = a[1] ? rd[31:16] : rd[15:0];
    r    = 32'h0000_0000;
    case (size)
      SZ_BYTE:  r = {{24{sgn & lane[7]}}, lane[7:0]};
      SZ_HALF:  r = {{16{sgn & half[15]}}, half};
      SZ_WORD:  r = rd;
      SZ_LEFT:  r = (rd << {~a, 3'b000}) | (d & ~(32'hFFFF_FFFF << {~a, 3'b000}));
      SZ_RIGHT: r = (rd >> {a, 3'b000}) | (d & ~(32'hFFFF_FFFF >> {a, 3'b000}));
      default:  r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic                    is_load_q, is_load_d;
  logic [2:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [1:0]              a_q, a_d;
  logic [31:0]             data_q, data_d;
  logic [4:0]              reg_q, reg_d;
  logic [31:0]             result_q, result_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [31:0]             bus_wdata_q, bus_wdata_d;
  logic [3:0]              bus_be_q, bus_be_d;
  logic                    bus_read_q, bus_read_d;
  logic                    bus_write_q, bus_write_d;

`ifdef MM_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  logic       req_mem_s;
  logic       size_ok_s;
  logic       start_s;
  logic [1:0] a_in_s;

  assign a_in_s    = addr_i[1:0];
  assign req_mem_s = (mem_access_type == T_LOAD) || (mem_access_type == T_STORE);
  assign size_ok_s = (mem_access_size <= SZ_RIGHT);
  assign alignment_err = req_mem_s &&
                         (((mem_access_size == SZ_HALF) && a_in_s[0]) ||
                          ((mem_access_size == SZ_WORD) && (a_in_s != 2'b00)));
  assign start_s = (state_q == S_IDLE) && req_mem_s && size_ok_s && !alignment_err;

  assign stall_o    = start_s || (state_q == S_ACCESS);
  assign done_o     = (state_q == S_DONE);
  assign data_o     = (state_q == S_DONE) ? result_q : data_i;
  assign reg_addr_o = (state_q == S_DONE) ? reg_q : reg_addr_i;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;
  assign bus_read   = bus_read_q;
  assign bus_write  = bus_write_q;
`ifdef MM_BUS_TIMEOUT_EN
  assign bus_err    = err_q;
`else
  assign bus_err    = 1'b0;
`endif

  // Next-state logic: request capture, ack handling and the optional timeout abort
  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    size_d      = size_q;
    signed_d    = signed_q;
    a_d         = a_q;
    data_d      = data_q;
    reg_d       = reg_q;
    result_d    = result_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
`ifdef MM_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          is_load_d   = (mem_access_type == T_LOAD);
          size_d      = mem_access_size;
          signed_d    = mem_access_signed;
          a_d         = a_in_s;
          data_d      = data_i;
          reg_d       = reg_addr_i;
          bus_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
          bus_be_d    = lane_be(mem_access_size, a_in_s, mem_access_type == T_LOAD);
          bus_wdata_d = (mem_access_type == T_STORE) ?
                        lane_wdata(mem_access_size, a_in_s, data_i) : 32'h0000_0000;
          bus_read_d  = (mem_access_type == T_LOAD);
          bus_write_d = (mem_access_type == T_STORE);
`ifdef MM_BUS_TIMEOUT_EN
          cnt_d       = '0;
`endif
          state_d     = S_ACCESS;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (bus_ack) begin
          result_d    = is_load_q ? load_fmt(size_q, signed_q, a_q, data_q, bus_rdata) : data_q;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          bus_be_d    = 4'b0000;
          state_d     = S_DONE;
        end else begin
`ifdef MM_BUS_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            result_d    = 32'h0000_0000;
            bus_read_d  = 1'b0;
            bus_write_d = 1'b0;
            bus_be_d    = 4'b0000;
            err_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d     = S_ACCESS;
          end
`else
          state_d = S_ACCESS;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_load_q   <= 1'b0;
      size_q      <= 3'd0;
      signed_q    <= 1'b0;
      a_q         <= 2'd0;
      data_q      <= 32'h0000_0000;
      reg_q       <= 5'd0;
      result_q    <= 32'h0000_0000;
      bus_addr_q  <= '0;
      bus_wdata_q <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
`ifdef MM_BUS_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      a_q         <= a_d;
      data_q      <= data_d;
      reg_q       <= reg_d;
      result_q    <= result_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
`ifdef MM_BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: doc/mm_bus_stage.md
Name: mm_bus_stage

Overview:
Memory-access pipeline stage that replaces the purely combinational MM step with a handshaked bus master. It accepts one load/store per request from EX, drives a word-aligned SRAM/bus transaction with byte enables, and waits for an ack. Loads are extracted, extended or merged (LB/LH/LW/LWL/LWR). The stage stalls the pipeline for the whole access and reports alignment and, optionally, bus-timeout errors.

Parameters:
ADDR_WIDTH, 32, width of addr_i and bus_addr; must be >= 3.
TIMEOUT_CYCLES, 255, number of ACCESS cycles without bus_ack before an abort (only with MM_BUS_TIMEOUT_EN); counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_access_type  in  2  0=NONE, 1=M2R (load), 2=R2M (store), 3=NONE
mem_access_size  in  3  0=BYTE, 1=HALF, 2=WORD, 3=LEFT_WORD, 4=RIGHT_WORD, others=invalid (treated as NONE)
mem_access_signed  in  1  sign-extend BYTE/HALF loads
addr_i  in  ADDR_WIDTH  byte address from EX
data_i  in  32  store data, or old rt value for LWL/LWR, or ALU result for non-memory ops
reg_addr_i  in  5  destination register from EX
data_o  out  32  result to WB/bypass mux
reg_addr_o  out  5  destination register to WB/bypass mux
done_o  out  1  one-cycle pulse; memory result valid on data_o
stall_o  out  1  freeze IF..EX while high
alignment_err  out  1  misaligned HALF/WORD access, combinational
bus_err  out  1  one-cycle timeout pulse
bus_addr  out  ADDR_WIDTH  {addr[ADDR_WIDTH-1:2],2'b00}, registered
bus_wdata  out  32  lane-positioned store data, registered
bus_be  out  4  byte enables, bit n = byte lane n (little-endian)
bus_read  out  1  load request level
bus_write  out  1  store request level
bus_ack  in  1  transaction complete; bus_rdata valid in same cycle
bus_rdata  in  32  read word

Behaviour:
- Reset: state=IDLE. bus_read, bus_write, bus_be, bus_addr, bus_wdata, done_o, bus_err and all latched request registers = 0. Reset asserted mid-access aborts the access immediately; no retry.
- start = state==IDLE && type in {1,2} && size valid && !alignment_err.
- alignment_err = type in {1,2} && ((size==HALF && a[0]) || (size==WORD && a[1:0]!=0)), where a = addr_i[1:0]. Misaligned requests are never accepted: no bus activity, stall_o=0. EX/exception logic consumes the error.
- States:
  - IDLE: on start, latch type/size/signed/a/data_i/reg_addr_i, load the bus registers and go to ACCESS.
  - ACCESS: hold the bus outputs stable. When bus_ack is sampled high, capture the formatted result, clear bus_read/bus_write/bus_be and go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- stall_o = start || state==ACCESS. stall_o is low in DONE so the pipeline advances. Minimum latency is accept -> ACCESS -> ack -> DONE, i.e. 3 cycles when ack arrives in the first ACCESS cycle.
- bus_ack outside ACCESS is ignored.
- data_o / reg_addr_o: latched values in DONE; otherwise combinational pass-through of data_i / reg_addr_i, so non-memory ops flow with 0 extra latency.
- Store lanes:
  - BYTE: be = 1<<a, wdata = {4{d[7:0]}}.
  - HALF: be = a[1] ? 1100 : 0011, wdata = {2{d[15:0]}}.
  - WORD: be = 1111, wdata = d.
  - SWL: be = (1<<(a+1))-1, wdata = d >> 8*(3-a).
  - SWR: be = 1111<<a (4-bit truncated), wdata = d << 8*a.
- Loads: for BYTE/HALF/WORD, be = the store-rule be; for LWL/LWR, be = 1111. Result rules:
  - BYTE: lane a, sign- or zero-extended.
  - HALF: lane a[1], sign- or zero-extended.
  - WORD: rdata.
  - LWL: (rdata << 8*(3-a)) | (d & ~(32'hFFFFFFFF << 8*(3-a))).
  - LWR: (rdata >> 8*a) | (d & ~(32'hFFFFFFFF >> 8*a)).
- Stores: data_o in DONE = latched d.

Optional Feature:
MM_BUS_TIMEOUT_EN:
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES, deassert the bus, pulse bus_err for 1 cycle and go to DONE with data_o=0. If ack arrives in the same cycle as the timeout, ack wins and bus_err stays 0.
- Undefined: no counter; ACCESS waits indefinitely; bus_err tied 0.

Test Plan:
- LB signed, addr=0x1003, ack after 2 cycles, rdata=0x80FF_0000 -> bus_addr=0x1000, be=1000, bus_read high 2 cycles, done_o pulse with data_o=0xFFFF_FF80, stall_o high for exactly 3 cycles.
- SH, addr=0x2002, data_i=0x1234_ABCD, immediate ack -> be=1100, wdata=0xABCD_ABCD, bus_write for 1 cycle, done_o, data_o=0x1234_ABCD.
- LWL addr=0x01, data_i=0xAABB_CCDD, rdata=0x4433_2211 -> data_o=0x2211_CCDD; LWR same address -> data_o=0xAA44_3322. SWL addr=0x01, data_i=0x1122_3344 -> be=0011, wdata=0x0000_1122.
- LW addr=0x0006 -> alignment_err=1, bus_read=0, stall_o=0, done_o=0. Type NONE with data_i=0x55 -> data_o=0x55 same cycle.
- rst_n pulled low during ACCESS -> bus_read/bus_write/bus_be=0 and state IDLE immediately. A later ack is ignored with no done_o.
- With MM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err pulse after 4 ACCESS cycles, done_o with data_o=0. Without the macro the same stimulus stalls indefinitely.
